icap_reg_arbiter: RTL and testbench
===================================

ICAP_REG_ARBITER -- requirements
Module: icap_reg_arbiter

Interface
REQ-001 SHALL have parameter BOOT_DELAY, default 16: cycles after reset before the first ICAP access.
REQ-002 SHALL have parameter READ_LATENCY, default 3: cycles from cs_n reassert in read mode to valid icap_dout.
REQ-003 SHALL have port clk  in  1  single clock for all logic; ICAPE2 CLK is driven from the same net.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req0/req1  in  1  level request per requester, held until the matching done.
REQ-006 SHALL have ports wr0/wr1  in  1  1 = register write, 0 = register read.
REQ-007 SHALL have ports addr0/addr1  in  5  configuration register address.
REQ-008 SHALL have ports wdata0/wdata1  in  32  write data.
REQ-009 SHALL have ports done0/done1  out  1  one-cycle completion pulse.
REQ-010 SHALL have ports err0/err1  out  1  valid with done; 1 = request rejected.
REQ-011 SHALL have port rdata  out  32  read result, valid with done.
REQ-012 SHALL have port grant  out  1  index of the requester currently being served.
REQ-013 SHALL have ports icap_cs_n, icap_wr_n  out  1 each  to ICAPE2 CSIB/RDWRB; icap_din  out  32; icap_dout  in  32.

Function
REQ-014 SHALL bit-reverse each byte of icap_din and icap_dout internally; all words below are logical (unswapped) values.
REQ-015 SHALL implement states BOOT, IDLE, SYNC, NOP, HDR, WDATA, RPIPE, RTURN, RWAIT, DESYNC.
REQ-016 BOOT: SHALL hold cs_n=1 and wr_n=1 for BOOT_DELAY cycles, then go to IDLE; requests SHALL be ignored.
REQ-017 IDLE: SHALL drive cs_n=1, wr_n=0, din=0x20000000; on any asserted req, SHALL latch grant, wr, addr and wdata, then go to SYNC the next cycle.
REQ-018 Arbitration: with both requests asserted, SHALL grant the requester not served last; after reset, requester 0 wins the first tie.
REQ-019 SYNC: SHALL drive cs_n=0, wr_n=0, din=0xAA995566 for 1 cycle; NOP: SHALL drive din=0x20000000 for 2 cycles.
REQ-020 HDR: SHALL drive din = 0x20000001 | op<<27 | addr<<13, with op=2 for a write and op=1 for a read (read IDCODE = 0x28018001).
REQ-021 Write path: WDATA SHALL drive din=wdata for 1 cycle, then go to DESYNC.
REQ-022 Read path: RPIPE SHALL drive 2 NOP cycles; RTURN SHALL drive cs_n=1 for 1 cycle, then wr_n=1 for 1 cycle, then cs_n=0.
REQ-023 RWAIT: SHALL capture icap_dout into rdata exactly READ_LATENCY cycles after cs_n=0; one cycle later SHALL set cs_n=1; one cycle after that SHALL set wr_n=0; then go to DESYNC.
REQ-024 DESYNC: SHALL hold cs_n=0 while driving din 0x30008001, 0x0000000D, 0x20000000, 0x20000000 on 4 consecutive cycles, then cs_n=1.
REQ-025 SHALL pulse done and err=0 for the granted requester on the cycle cs_n returns to 1 at the end of DESYNC, then return to IDLE.
REQ-026 SHALL ignore an ungranted requester until the current transaction completes; its request SHALL NOT be lost.
REQ-027 rdata SHALL hold its last captured value until the next read capture; write transactions SHALL NOT alter it.
REQ-028 Deasserting req before done is illegal; the transaction SHALL still complete and pulse done.

Reset
REQ-029 Reset SHALL asynchronously force cs_n=1, wr_n=1, din=0xFFFFFFFF, done=0, err=0, rdata=0, grant=0, state=BOOT, and reload the boot counter.
REQ-030 Reset mid-transaction SHALL abort without a done pulse; a request still asserted after BOOT SHALL be re-served from SYNC.

Configuration
REQ-031 Macro ICAP_REG_WRITE_EN defined: write requests SHALL execute per REQ-021.
REQ-032 Macro ICAP_REG_WRITE_EN undefined: a granted write SHALL NOT touch the ICAP (cs_n stays 1); done=1 and err=1 SHALL pulse the cycle after grant, then return to IDLE. Reads SHALL be unaffected.

Verification
REQ-033 Read: req0=1, wr0=0, addr0=0x0C, ICAP model returns 0x3631093 -> header 0x28018001 seen; done0 pulses; rdata=0x03631093; err0=0.
REQ-034 Write with macro defined: req1=1, wr1=1, addr1=0x04, wdata1=0x0000000D -> header 0x30008001 then 0x0000000D on icap_din; done1 pulses; err1=0.
REQ-035 Tie: req0=req1=1 from IDLE after reset -> requester 0 served first, requester 1 next; done0 precedes done1; repeated tie alternates.
REQ-036 Macro undefined: write request on req0 -> cs_n stays 1; done0=err0=1 the cycle after grant.
REQ-037 Async rst asserted during RWAIT -> cs_n=1, wr_n=1 immediately with no clock edge; no done; after BOOT_DELAY=16 cycles the held request completes.
REQ-038 Request during BOOT -> no cs_n activity until BOOT_DELAY expires; SYNC follows 1 cycle after IDLE is entered.

Source files
------------

// File: rtl/icap_reg_arbiter.sv
// Two-requester arbiter that runs register reads/writes through an ICAPE2 port.
// Define ICAP_REG_WRITE_EN to let writes reach the ICAP; otherwise writes are rejected with err.
module icap_reg_arbiter #(
  parameter int BOOT_DELAY   = 16,
  parameter int READ_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [4:0]  addr0,
  input  logic [4:0]  addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata,
  output logic        grant,
  output logic        icap_cs_n,
  output logic        icap_wr_n,
  output logic [31:0] icap_din,
  input  logic [31:0] icap_dout
);

  typedef enum logic [3:0] {
    BOOT, IDLE, SYNC, NOP, HDR, WDATA, RPIPE, RTURN, RWAIT, DESYNC
  } state_t;

  localparam int CW = 16;
  localparam logic [CW-1:0] BOOT_LAST   = CW'(BOOT_DELAY - 1);
  localparam logic [CW-1:0] CAP_CNT     = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] RD_LAST_LOW = CW'(READ_LATENCY);
  localparam logic [CW-1:0] RWAIT_LAST  = CW'(READ_LATENCY + 2);

  localparam logic [31:0] W_NOP    = 32'h2000_0000;
  localparam logic [31:0] W_SYNC   = 32'hAA99_5566;
  localparam logic [31:0] W_DS_HDR = 32'h3000_8001;
  localparam logic [31:0] W_DS_CMD = 32'h0000_000D;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cs_n_q, cs_n_d, wr_n_q, wr_n_d;
  logic [31:0]     din_q, din_d;
  logic            done_q, done_d, err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            grant_q, grant_d, last_q, last_d;
  logic            op_wr_q, op_wr_d;
  logic [4:0]      addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            pick;
  logic [31:0]     hdr;

  // ICAPE2 expects each byte bit-reversed on both data buses.
  function automatic logic [31:0] bitswap(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 8; i++)
        r[8*b+i] = w[8*b+7-i];
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    grant_d = grant_q;
    last_d  = last_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pick    = 1'b0;

    case (state_q)
      BOOT:
        if (cnt_q == BOOT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      IDLE: begin
        cnt_d = '0;
        // Skip the done cycle so a requester still holding req is not re-served.
        if (!done_q && (req0 || req1)) begin
          pick    = (req0 && req1) ? ~last_q : req1;
          grant_d = pick;
          last_d  = pick;
          op_wr_d = pick ? wr1 : wr0;
          addr_d  = pick ? addr1 : addr0;
          wdata_d = pick ? wdata1 : wdata0;
`ifdef ICAP_REG_WRITE_EN
          state_d = SYNC;
`else
          if (op_wr_d) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d = SYNC;
          end
`endif
        end
      end
      SYNC: begin
        state_d = NOP;
        cnt_d   = '0;
      end
      NOP:
        if (cnt_q == 16'd1) begin
          state_d = HDR;
          cnt_d   = '0;
        end
      HDR: begin
        state_d = op_wr_q ? WDATA : RPIPE;
        cnt_d   = '0;
      end
      WDATA: begin
        state_d = DESYNC;
        cnt_d   = '0;
      end
      RPIPE:
        if (cnt_q == 16'd1) begin
          state_d = RTURN;
          cnt_d   = '0;
        end
      RTURN:
        if (cnt_q == 16'd1) begin
          state_d = RWAIT;
          cnt_d   = '0;
        end
      RWAIT: begin
        if (cnt_q == CAP_CNT)
          rdata_d = bitswap(icap_dout);
        if (cnt_q == RWAIT_LAST) begin
          state_d = DESYNC;
          cnt_d   = '0;
        end
      end
      DESYNC:
        if (cnt_q == 16'd3) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      default: begin
        state_d = BOOT;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    hdr = W_NOP | 32'h1 | (op_wr_d ? 32'h1000_0000 : 32'h0800_0000) | {14'd0, addr_d, 13'd0};
    cs_n_d = 1'b1;
    wr_n_d = 1'b0;
    din_d  = W_NOP;
    case (state_d)
      BOOT: begin
        wr_n_d = 1'b1;
        din_d  = 32'hFFFF_FFFF;
      end
      SYNC: begin
        cs_n_d = 1'b0;
        din_d  = W_SYNC;
      end
      NOP, RPIPE: cs_n_d = 1'b0;
      HDR: begin
        cs_n_d = 1'b0;
        din_d  = hdr;
      end
      WDATA: begin
        cs_n_d = 1'b0;
        din_d  = wdata_d;
      end
      RTURN: wr_n_d = (cnt_d == 16'd1);
      RWAIT: begin
        cs_n_d = (cnt_d > RD_LAST_LOW);
        wr_n_d = (cnt_d != RWAIT_LAST);
      end
      DESYNC: begin
        cs_n_d = 1'b0;
        case (cnt_d[1:0])
          2'd0:    din_d = W_DS_HDR;
          2'd1:    din_d = W_DS_CMD;
          default: din_d = W_NOP;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      cnt_q   <= '0;
      cs_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      din_q   <= 32'hFFFF_FFFF;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_n_q  <= cs_n_d;
      wr_n_q  <= wr_n_d;
      din_q   <= din_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign done0     = done_q & ~grant_q;
  assign done1     = done_q & grant_q;
  assign err0      = err_q & ~grant_q;
  assign err1      = err_q & grant_q;
  assign rdata     = rdata_q;
  assign grant     = grant_q;
  assign icap_cs_n = cs_n_q;
  assign icap_wr_n = wr_n_q;
  assign icap_din  = bitswap(din_q);

endmodule

// File: tb/tb_icap_reg_arbiter.sv
// Directed bench for icap_reg_arbiter: vector table plus boot, async-reset and tie sequences.
// Expectations follow ICAP_REG_WRITE_EN when the bench is compiled with it.
module tb_icap_reg_arbiter;

  localparam int RL = 3;
`ifdef ICAP_REG_WRITE_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  logic        clk, rst;
  logic        req0, req1, wr0, wr1;
  logic [4:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        done0, done1, err0, err1, grant;
  logic [31:0] rdata;
  logic        icap_cs_n, icap_wr_n;
  logic [31:0] icap_din, icap_dout;

  icap_reg_arbiter #(.BOOT_DELAY(16), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .rdata(rdata), .grant(grant),
    .icap_cs_n(icap_cs_n), .icap_wr_n(icap_wr_n),
    .icap_din(icap_din), .icap_dout(icap_dout)
  );

  typedef struct {
    logic        rq;
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] icap_val;
    logic [31:0] exp_hdr;
    logic        exp_err;
    int          exp_lat;
    int          exp_cslow;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs[5];
  int          total = 0;
  int          passed = 0;
  logic [31:0] icap_val = 32'h0;
  int          rd_cnt = 0;
  int          cs_low_cnt = 0;
  logic [31:0] din_log[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] bitswap(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 8; i++)
        r[8*b+i] = w[8*b+7-i];
    return r;
  endfunction

  // ICAP read model: data is valid only on the cycle READ_LATENCY after cs_n fell in read mode.
  always @(negedge clk) begin
    if (!icap_cs_n && icap_wr_n) rd_cnt = rd_cnt + 1;
    else rd_cnt = 0;
    icap_dout = (rd_cnt == RL) ? bitswap(icap_val) : 32'h0BAD_F00D;
  end

  always @(negedge clk) begin
    if (!icap_cs_n) cs_low_cnt = cs_low_cnt + 1;
    if (!icap_cs_n && !icap_wr_n) din_log.push_back(bitswap(icap_din));
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act === exp) passed = passed + 1;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic waitDone(input int bound, output int lat, output int first_cs);
    lat = 0;
    first_cs = 0;
    for (int c = 1; c <= bound; c++) begin
      @(negedge clk);
      if (first_cs == 0 && !icap_cs_n) first_cs = c;
      if (done0 || done1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    int          lat, first_cs, mism;
    logic        d0, d1, e, g;
    logic [31:0] rd;
    logic [31:0] exp_q[$];
    din_log.delete();
    cs_low_cnt = 0;
    icap_val = v.icap_val;
    if (v.rq == 1'b0) begin
      wr0 = v.wr; addr0 = v.addr; wdata0 = v.wdata; req0 = 1'b1;
    end else begin
      wr1 = v.wr; addr1 = v.addr; wdata1 = v.wdata; req1 = 1'b1;
    end
    waitDone(100, lat, first_cs);
    d0 = done0; d1 = done1; g = grant; rd = rdata;
    e = v.rq ? err1 : err0;
    req0 = 1'b0;
    req1 = 1'b0;

    if (!v.wr || WR_EN) begin
      exp_q.push_back(32'hAA99_5566);
      exp_q.push_back(32'h2000_0000);
      exp_q.push_back(32'h2000_0000);
      exp_q.push_back(v.exp_hdr);
      if (v.wr) exp_q.push_back(v.wdata);
      else begin
        exp_q.push_back(32'h2000_0000);
        exp_q.push_back(32'h2000_0000);
      end
      exp_q.push_back(32'h3000_8001);
      exp_q.push_back(32'h0000_000D);
      exp_q.push_back(32'h2000_0000);
      exp_q.push_back(32'h2000_0000);
    end
    mism = 0;
    for (int i = 0; i < exp_q.size() && i < din_log.size(); i++)
      if (din_log[i] !== exp_q[i]) mism = mism + 1;

    checkOutput($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
    checkOutput($sformatf("v%0d_done0", idx), {31'd0, d0}, {31'd0, ~v.rq});
    checkOutput($sformatf("v%0d_done1", idx), {31'd0, d1}, {31'd0, v.rq});
    checkOutput($sformatf("v%0d_err", idx), {31'd0, e}, {31'd0, v.exp_err});
    checkOutput($sformatf("v%0d_grant", idx), {31'd0, g}, {31'd0, v.rq});
    checkOutput($sformatf("v%0d_cs_low_cycles", idx), 32'(cs_low_cnt), 32'(v.exp_cslow));
    checkOutput($sformatf("v%0d_din_count", idx), 32'(din_log.size()), 32'(exp_q.size()));
    checkOutput($sformatf("v%0d_din_words_wrong", idx), 32'(mism), 32'd0);
    checkOutput($sformatf("v%0d_rdata", idx), rd, v.exp_rdata);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int lat, first_cs, found;
    int exp_order[3];

    vecs[0] = '{1'b0, 1'b0, 5'h0C, 32'h0, 32'h0363_1093, 32'h2801_8001, 1'b0, 19, 14, 32'h0363_1093};
    vecs[1] = '{1'b1, 1'b1, 5'h04, 32'h0000_000D, 32'h0, 32'h3000_8001, !WR_EN,
                WR_EN ? 10 : 1, WR_EN ? 9 : 0, 32'h0363_1093};
    vecs[2] = '{1'b1, 1'b0, 5'h1F, 32'h0, 32'hA5C3_0F01, 32'h2803_E001, 1'b0, 19, 14, 32'hA5C3_0F01};
    vecs[3] = '{1'b0, 1'b1, 5'h10, 32'hDEAD_BEEF, 32'h0, 32'h3002_0001, !WR_EN,
                WR_EN ? 10 : 1, WR_EN ? 9 : 0, 32'hA5C3_0F01};
    vecs[4] = '{1'b0, 1'b0, 5'h00, 32'h0, 32'hFFFF_0000, 32'h2800_0001, 1'b0, 19, 14, 32'hFFFF_0000};

    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    #3;
    checkOutput("reset_cs_n", {31'd0, icap_cs_n}, 32'd1);
    checkOutput("reset_wr_n", {31'd0, icap_wr_n}, 32'd1);
    checkOutput("reset_din", icap_din, 32'hFFFF_FFFF);
    checkOutput("reset_done", {30'd0, done1, done0}, 32'd0);
    checkOutput("reset_rdata", rdata, 32'd0);
    checkOutput("reset_grant", {31'd0, grant}, 32'd0);

    $display("[TB] boot with read request held");
    icap_val = 32'h0363_1093;
    addr0 = 5'h0C; wr0 = 1'b0; req0 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    waitDone(100, lat, first_cs);
    checkOutput("boot_first_cs_low", 32'(first_cs), 32'd17);
    checkOutput("boot_latency", 32'(lat), 32'd35);
    checkOutput("boot_done0", {31'd0, done0}, 32'd1);
    checkOutput("boot_err0", {31'd0, err0}, 32'd0);
    checkOutput("boot_rdata", rdata, 32'h0363_1093);
    req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("[TB] vector table");
    for (int i = 0; i < 5; i++) applyStimulus(i, vecs[i]);

    $display("[TB] async reset during read wait");
    icap_val = 32'h1234_5678;
    addr0 = 5'h0C; wr0 = 1'b0; req0 = 1'b1;
    found = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!icap_cs_n && icap_wr_n) begin
        found = 1;
        break;
      end
    end
    checkOutput("rwait_reached", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_cs_n", {31'd0, icap_cs_n}, 32'd1);
    checkOutput("async_rst_wr_n", {31'd0, icap_wr_n}, 32'd1);
    checkOutput("async_rst_done0", {31'd0, done0}, 32'd0);
    checkOutput("async_rst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    waitDone(100, lat, first_cs);
    checkOutput("rerun_first_cs_low", 32'(first_cs), 32'd17);
    checkOutput("rerun_latency", 32'(lat), 32'd35);
    checkOutput("rerun_done0", {31'd0, done0}, 32'd1);
    checkOutput("rerun_rdata", rdata, 32'h1234_5678);
    req0 = 1'b0;
    @(negedge clk);

    $display("[TB] tie after reset");
    exp_order = '{0, 1, 0};
    rst = 1'b1;
    icap_val = 32'h55AA_33CC;
    addr0 = 5'h0C; addr1 = 5'h01; wr0 = 1'b0; wr1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      waitDone(100, lat, first_cs);
      checkOutput($sformatf("tie%0d_done0", k), {31'd0, done0}, {31'd0, exp_order[k] == 0});
      checkOutput($sformatf("tie%0d_done1", k), {31'd0, done1}, {31'd0, exp_order[k] == 1});
      checkOutput($sformatf("tie%0d_err", k), {30'd0, err1, err0}, 32'd0);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
